decrement_unloader: RTL and testbench
=====================================

// Module: decrement_unloader
// PURPOSE
//  Consumer end of the registered-increment datapath: accepts words that were
//  produced as (value + 1) and recovers value = word - 1 mod 2^DataWidth.
//  Valid/ready stream in and out, 2-entry elastic buffer for full throughput.
//  Counts delivered words. Sits between the incrementing producer and any sink.
// PARAMETERS
//  DataWidth   16  width of in_data / out_data
//  CountWidth  8   width of word_count (wraps)
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           async active-low reset
//  in_data     in   DataWidth   incremented word from producer
//  in_valid    in   1           in_data valid
//  in_ready    out  1           buffer can accept (state != TWO)
//  out_data    out  DataWidth   recovered word (registered)
//  out_valid   out  1           out_data valid (registered)
//  out_ready   in   1           sink accepts out_data
//  word_count  out  CountWidth  number of out handshakes, mod 2^CountWidth
//  underflow   out  1           sticky; only with DECUNLOAD_UNDERFLOW_EN
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst_n=0, async): state=EMPTY, out_valid=0, out_data=0,
//    word_count=0, underflow=0; in_ready=1 (comb from state).
//  - Accept = in_valid & in_ready; deliver = out_valid & out_ready.
//  - Decrement applied at accept; stored entries already hold word-1.
//    in_data=0 -> stored all-ones (wrap, no saturation).
//  - Latency: accepted word visible on out_data next cycle when buffer empty.
//  - FSM states EMPTY (0 held), ONE (out reg full), TWO (out + skid full):
//    EMPTY: accept -> ONE.
//    ONE:   accept&deliver -> ONE (out <= new); accept only -> TWO (skid <= new);
//           deliver only -> EMPTY.
//    TWO:   in_ready=0; deliver -> ONE (out <= skid); else hold.
//  - Order strictly FIFO; no word dropped or duplicated.
//  - out_data/out_valid stable while out_valid & ~out_ready.
//  - Throughput: 1 word/cycle sustained when out_ready held high.
//  - word_count increments on every deliver; wraps 2^CountWidth-1 -> 0.
//  - in_valid while in_ready=0: ignored, no state change.
//  - rst_n low mid-stream: buffered words discarded, outputs to reset values
//    immediately; first accept after release behaves as from EMPTY.
// CONFIGURATION
//  DECUNLOAD_UNDERFLOW_EN defined: underflow set on accept of in_data==0
//   (decrement wraps); stays 1 until rst_n. Data path unchanged.
//  Undefined: underflow port tied 0; no detection logic.
// STRUCTURE
//  Package decunload_pkg: typedef enum {EMPTY,ONE,TWO} decunload_state_t;
//   localparam encodings; decrement function dec_word(). 
//  Sub-module unload_buffer: 2-entry skid buffer (FSM + out/skid regs),
//   parameterised by DataWidth. Top holds decrement, counter, underflow.
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, out_data=0, word_count=0, in_ready=1.
//  2 Stream 5,6,7 with out_ready=1 -> out_data 4,5,6 on consecutive cycles,
//    each one cycle after accept; word_count=3.
//  3 Backpressure: out_ready=0, send 10,20,30 -> only 10,20 accepted,
//    in_ready=0 in TWO; release -> 9,19 then 29 after re-accept; order kept.
//  4 Wrap: in_data=0x0000 -> out_data=0xFFFF; underflow=1 iff
//    DECUNLOAD_UNDERFLOW_EN, sticky across later words.
//  5 Counter wrap (CountWidth=8): 256 delivers -> word_count=0.
//  6 Async reset asserted with TWO occupied -> out_valid=0 same cycle,
//    in_ready=1; next word 3 -> out_data=2, word_count=1.

Source files
------------

// File: rtl/decunload_pkg.sv
// decunload_pkg
//   Shared definitions for the decrement_unloader slice:
//   - state encodings and the decunload_state_t enum used by the skid buffer
//   - dec_word(): recovers the original value from an incremented word
//   Optional feature macro: DECUNLOAD_UNDERFLOW_EN (used by the top only).
package decunload_pkg;

  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_ONE_ENC   = 2'd1;
  localparam logic [1:0] ST_TWO_ENC   = 2'd2;

  // EMPTY: nothing held, ONE: output register full, TWO: output + skid full
  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY_ENC,
    ONE   = ST_ONE_ENC,
    TWO   = ST_TWO_ENC
  } decunload_state_t;

  // Works on a wide container so any DataWidth up to 64 can use it; the caller
  // keeps only its low DataWidth bits, which is exactly word - 1 mod 2^DataWidth
  // (a zero word wraps to all ones rather than saturating).
  function automatic logic [63:0] dec_word(input logic [63:0] word);
    return word - 64'd1;
  endfunction

endpackage

// File: rtl/unload_buffer.sv
// unload_buffer
//   Two-entry elastic (skid) buffer giving full throughput on a valid/ready
//   stream while keeping out_data/out_valid registered.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_data, in_valid    upstream word and its valid
//     in_ready             buffer can accept (state != TWO)
//     out_data, out_valid  registered head-of-queue word and its valid
//     out_ready            downstream accepts out_data
module unload_buffer #(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  import decunload_pkg::*;

  decunload_state_t     state_q;
  decunload_state_t     state_d;
  logic [DataWidth-1:0] out_data_q;
  logic [DataWidth-1:0] out_data_d;
  logic [DataWidth-1:0] skid_q;
  logic [DataWidth-1:0] skid_d;
  logic                 accept;
  logic                 deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers; skid only ever holds the word queued behind out_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      skid_q     <= '0;
    end else begin
      out_data_q <= out_data_d;
      skid_q     <= skid_d;
    end
  end

  // Next-state and datapath steering
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = in_data;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          out_data_d = in_data;
          state_d    = ONE;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the skid word can move forward
        if (deliver) begin
          out_data_d = skid_q;
          state_d    = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    out_data  = out_data_q;
  end

endmodule

// File: rtl/decrement_unloader.sv
// decrement_unloader
//   Consumer end of the registered-increment datapath. Accepts words produced
//   as value + 1, recovers value = word - 1 (mod 2^DataWidth) at accept time,
//   buffers them in a 2-entry skid buffer and counts delivered words.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_data, in_valid    incremented word from the producer
//     in_ready             buffer can accept
//     out_data, out_valid  recovered word (registered)
//     out_ready            sink accepts out_data
//     word_count           out handshakes, wraps mod 2^CountWidth
//     underflow            sticky flag, set when a zero word is accepted;
//                          only implemented with DECUNLOAD_UNDERFLOW_EN defined,
//                          otherwise tied to 0.
module decrement_unloader #(
  parameter int DataWidth  = 16,
  parameter int CountWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DataWidth-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DataWidth-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CountWidth-1:0] word_count,
  output logic                  underflow
);
  import decunload_pkg::*;

  logic [DataWidth-1:0]  dec_data;
  logic                  accept;
  logic                  deliver;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;

  // Decrement happens before buffering, so stored entries already hold word-1
  always_comb begin
    dec_data = DataWidth'(dec_word(64'(in_data)));
  end

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  unload_buffer #(
    .DataWidth(DataWidth)
  ) u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (dec_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Delivered-word counter, wraps naturally at 2^CountWidth
  always_comb begin
    count_d = count_q;
    if (deliver) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;

`ifdef DECUNLOAD_UNDERFLOW_EN
  logic underflow_q;
  logic underflow_d;

  // Sticky: once a zero word has been accepted the flag stays until reset
  always_comb begin
    underflow_d = underflow_q | (accept & (in_data == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_decrement_unloader.sv
module tb_decrement_unloader;

`ifdef DECUNLOAD_UNDERFLOW_EN
   localparam bit UnderflowEn = 1'b1;
`else
   localparam bit UnderflowEn = 1'b0;
`endif

   logic        clock;
   logic        rstN;
   logic [15:0] inData;
   logic        inValid;
   logic        inReady;
   logic [15:0] outData;
   logic        outValid;
   logic        outReady;
   logic [7:0]  wordCount;
   logic        underflowFlag;

   int          checkCount;
   int          passCount;
   int          modelCount;
   bit          modelUnderflow;
   bit          prevHeld;
   logic [15:0] prevData;
   int          expQ[$];

   decrement_unloader #(
      .DataWidth(16),
      .CountWidth(8)
   ) dut (
      .clk       (clock),
      .rst_n     (rstN),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .out_data  (outData),
      .out_valid (outValid),
      .out_ready (outReady),
      .word_count(wordCount),
      .underflow (underflowFlag)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference rule: the producer sent value+1, so value is one less, modulo 2^16
   function automatic int decModel(input int word);
      if (word == 0) return 65535;
      return word - 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Wait for the next rising edge, then drive inputs just after it
   task automatic applyStimulus(input int data, input bit valid, input bit oready);
      @(posedge clock);
      #1;
      inData   = data[15:0];
      inValid  = valid;
      outReady = oready;
   endtask

   // Input tracker: every accepted word pushes its expected recovered value
   always @(negedge clock) begin
      if (rstN && inValid && inReady) begin
         expQ.push_back(decModel(int'(inData)));
         if (inData == 16'd0 && UnderflowEn) modelUnderflow = 1'b1;
      end
   end

   // Output monitor: pops and compares on every delivered word
   always @(negedge clock) begin
      if (!rstN) begin
         prevHeld = 1'b0;
      end else begin
         if (prevHeld) begin
            checkOutput("hold_valid", 32'(outValid), 32'd1);
            checkOutput("hold_data", 32'(outData), 32'(prevData));
         end
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_output", 32'(outData), 32'hDEAD_BEEF);
            end else begin
               checkOutput("out_data", 32'(outData), 32'(expQ.pop_front()));
            end
            checkOutput("word_count", 32'(wordCount), 32'(modelCount % 256));
            modelCount++;
         end
         prevHeld = outValid && !outReady;
         prevData = outData;
      end
   end

   initial begin
      checkCount     = 0;
      passCount      = 0;
      modelCount     = 0;
      modelUnderflow = 1'b0;
      prevHeld       = 1'b0;
      prevData       = '0;
      rstN           = 1'b0;
      inData         = '0;
      inValid        = 1'b0;
      outReady       = 1'b0;

      // Reset state
      #3;
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_out_data", 32'(outData), 32'd0);
      checkOutput("rst_word_count", 32'(wordCount), 32'd0);
      checkOutput("rst_in_ready", 32'(inReady), 32'd1);
      checkOutput("rst_underflow", 32'(underflowFlag), 32'd0);
      @(negedge clock);
      @(negedge clock);
      rstN = 1'b1;

      // Streaming 5,6,7 with the sink always ready
      applyStimulus(5, 1, 1);
      applyStimulus(6, 1, 1);
      checkOutput("stream_first", 32'(outData), 32'd4);
      applyStimulus(7, 1, 1);
      checkOutput("stream_second", 32'(outData), 32'd5);
      applyStimulus(0, 0, 1);
      checkOutput("stream_third", 32'(outData), 32'd6);
      applyStimulus(0, 0, 1);
      checkOutput("stream_count", 32'(wordCount), 32'd3);
      checkOutput("stream_idle", 32'(outValid), 32'd0);

      // Backpressure: only two words fit, third waits for space
      applyStimulus(10, 1, 0);
      applyStimulus(20, 1, 0);
      checkOutput("bp_head", 32'(outData), 32'd9);
      applyStimulus(30, 1, 0);
      checkOutput("bp_full", 32'(inReady), 32'd0);
      applyStimulus(30, 1, 0);
      checkOutput("bp_still_full", 32'(inReady), 32'd0);
      checkOutput("bp_head_held", 32'(outData), 32'd9);
      applyStimulus(30, 1, 1);
      applyStimulus(30, 1, 1);
      checkOutput("bp_skid_forward", 32'(outData), 32'd19);
      checkOutput("bp_ready_again", 32'(inReady), 32'd1);
      applyStimulus(0, 0, 1);
      checkOutput("bp_third", 32'(outData), 32'd29);
      applyStimulus(0, 0, 1);

      // Zero word wraps to all ones; underflow is sticky when enabled
      applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      checkOutput("wrap_data", 32'(outData), 32'hFFFF);
      checkOutput("wrap_underflow", 32'(underflowFlag), 32'(UnderflowEn));
      applyStimulus(8, 1, 1);
      applyStimulus(0, 0, 1);
      checkOutput("after_wrap_data", 32'(outData), 32'd7);
      checkOutput("underflow_sticky", 32'(underflowFlag), 32'(UnderflowEn));
      applyStimulus(0, 0, 1);

      // Asynchronous reset while both entries are occupied
      applyStimulus(40, 1, 0);
      applyStimulus(50, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("pre_reset_full", 32'(inReady), 32'd0);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("areset_out_valid", 32'(outValid), 32'd0);
      checkOutput("areset_in_ready", 32'(inReady), 32'd1);
      checkOutput("areset_out_data", 32'(outData), 32'd0);
      checkOutput("areset_count", 32'(wordCount), 32'd0);
      checkOutput("areset_underflow", 32'(underflowFlag), 32'd0);
      expQ.delete();
      modelCount     = 0;
      modelUnderflow = 1'b0;
      @(negedge clock);
      @(negedge clock);
      rstN = 1'b1;
      applyStimulus(3, 1, 1);
      applyStimulus(0, 0, 1);
      checkOutput("post_reset_data", 32'(outData), 32'd2);
      checkOutput("post_reset_valid", 32'(outValid), 32'd1);
      applyStimulus(0, 0, 1);
      checkOutput("post_reset_count", 32'(wordCount), 32'd1);

      // 255 more delivers bring the counter from 1 round to 0
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1 + (i % 100), 1, 1);
      end
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput("count_wrap", 32'(wordCount), 32'd0);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 65535)),
                       bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end

      // Drain with a bounded budget
      for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
         applyStimulus(0, 0, 1);
      end
      applyStimulus(0, 0, 1);
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
      checkOutput("drain_idle", 32'(outValid), 32'd0);
      checkOutput("final_count", 32'(wordCount), 32'(modelCount % 256));
      checkOutput("final_underflow", 32'(underflowFlag), 32'(modelUnderflow));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
